// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// and the select/operation codes driven towards the datapath.
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR,
        MEM_RD, MEM_WR, WB_MEM, BRANCH, JAL, TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR  = 3'b011,
        ALU_XOR = 3'b100, ALU_SLT = 3'b101, ALU_SLL = 3'b110, ALU_SRL = 3'b111
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2
    } result_src_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side.
interface multicycle_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] instr;
    logic                  eq;
    logic                  mem_ready;
    logic                  mem_req;
    logic                  mem_we;
    logic                  addr_src;
    logic                  ir_we;
    logic                  pc_we;
    logic                  pc_src;
    logic                  regwrite;
    logic [1:0]            result_src;
    logic                  alu_src;
    logic [2:0]            alu_ctrl;
    logic [2:0]            imm_src;
    logic                  illegal;

    modport master (
        input  instr, eq, mem_ready,
        output mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, regwrite,
               result_src, alu_src, alu_ctrl, imm_src, illegal
    );

    modport slave (
        output instr, eq, mem_ready,
        input  mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, regwrite,
               result_src, alu_src, alu_ctrl, imm_src, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps opcode/funct3/funct7 to an ALU operation and flags encodings the
// controller does not support, so DECODE can branch to TRAP.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_ctrl_t  alu_ctrl,
    output logic       legal
);
    logic f7_ok;

    // On I-type only the shifts carry funct7; elsewhere those bits are immediate.
    assign f7_ok = (funct7 == 7'b0000000) ||
                   ((opcode == OP_I) && (funct3 != 3'b001) && (funct3 != 3'b101));

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        case (opcode)
            OP_R, OP_I: begin
                case (funct3)
                    3'b000: begin
                        if ((opcode == OP_R) && (funct7 == 7'b0100000)) begin
                            alu_ctrl = ALU_SUB;
                            legal    = 1'b1;
                        end else begin
                            legal = f7_ok;
                        end
                    end
                    3'b111: begin alu_ctrl = ALU_AND; legal = f7_ok; end
                    3'b110: begin alu_ctrl = ALU_OR;  legal = f7_ok; end
                    3'b100: begin alu_ctrl = ALU_XOR; legal = f7_ok; end
                    3'b010: begin alu_ctrl = ALU_SLT; legal = f7_ok; end
                    3'b001: begin alu_ctrl = ALU_SLL; legal = f7_ok; end
                    3'b101: begin alu_ctrl = ALU_SRL; legal = f7_ok; end
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD, OP_STORE: legal = (funct3 == 3'b010);
            OP_BRANCH: begin
                alu_ctrl = ALU_SUB;
                legal    = (funct3[2:1] == 2'b00);
            end
            OP_JAL:  legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM: sequences regfile/ALU datapath and a
// single unified memory port. Outputs are combinational from state and instr.
//
// state    | meaning
// FETCH    | read instruction at PC; on ready load IR and PC+4
// DECODE   | select path by opcode, trap on unsupported encodings
// EXEC_R   | ALU on rs1,rs2
// EXEC_I   | ALU on rs1,imm
// WB_ALU   | write ALU result to rd
// MEM_ADDR | compute rs1+imm for load/store
// MEM_RD   | data read at ALUout, wait for ready
// MEM_WR   | data write at ALUout, wait for ready
// WB_MEM   | write loaded data to rd
// BRANCH   | compare and conditionally take old_pc+imm
// JAL      | jump and write old_pc+4 to rd
// TRAP     | sticky illegal, no strobes until reset
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);
    state_t          state, state_nxt;
    logic [DATA_WIDTH-1:0] instr;
    logic [6:0]      opcode;
    alu_ctrl_t       dec_alu;
    logic            dec_legal;
    logic            unused_instr;

    logic            mem_req, mem_we, addr_src, ir_we, pc_we, pc_src;
    logic            regwrite, alu_src, illegal;
    result_src_t     result_src;
    alu_ctrl_t       alu_ctrl;
    imm_src_t        imm_src;

    assign instr        = bus.instr;
    assign opcode       = instr[6:0];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .opcode   (opcode),
        .funct3   (instr[14:12]),
        .funct7   (instr[31:25]),
        .alu_ctrl (dec_alu),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        regwrite   = 1'b0;
        result_src = RES_ALU;
        alu_src    = 1'b0;
        alu_ctrl   = ALU_ADD;
        imm_src    = IMM_I;
        illegal    = 1'b0;
        // Reset overrides everything so an in-flight transfer is dropped at once.
        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        ir_we     = 1'b1;
                        pc_we     = 1'b1;
                        state_nxt = DECODE;
                    end
                end
                DECODE: begin
                    if (!dec_legal) state_nxt = TRAP;
                    else begin
                        case (opcode)
                            OP_R:               state_nxt = EXEC_R;
                            OP_I:               state_nxt = EXEC_I;
                            OP_LOAD, OP_STORE:  state_nxt = MEM_ADDR;
                            OP_BRANCH:          state_nxt = BRANCH;
                            OP_JAL:             state_nxt = JAL;
                            default:            state_nxt = TRAP;
                        endcase
                    end
                end
                EXEC_R: begin
                    alu_ctrl  = dec_alu;
                    state_nxt = WB_ALU;
                end
                EXEC_I: begin
                    alu_src   = 1'b1;
                    alu_ctrl  = dec_alu;
                    state_nxt = WB_ALU;
                end
                WB_ALU: begin
                    regwrite  = 1'b1;
                    alu_src   = (opcode == OP_I);
                    alu_ctrl  = dec_alu;
                    state_nxt = FETCH;
                end
                MEM_ADDR: begin
                    alu_src   = 1'b1;
                    imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                    state_nxt = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    mem_req  = 1'b1;
                    addr_src = 1'b1;
                    if (bus.mem_ready) state_nxt = WB_MEM;
                end
                MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_src = 1'b1;
                    if (bus.mem_ready) state_nxt = FETCH;
                end
                WB_MEM: begin
                    regwrite   = 1'b1;
                    result_src = RES_MEM;
                    state_nxt  = FETCH;
                end
                BRANCH: begin
                    alu_ctrl  = ALU_SUB;
                    imm_src   = IMM_B;
                    pc_src    = 1'b1;
                    pc_we     = instr[12] ? ~bus.eq : bus.eq;
                    state_nxt = FETCH;
                end
                JAL: begin
                    imm_src    = IMM_J;
                    pc_src     = 1'b1;
                    pc_we      = 1'b1;
                    regwrite   = 1'b1;
                    result_src = RES_PC4;
                    state_nxt  = FETCH;
                end
                TRAP:    illegal = 1'b1;
                default: state_nxt = TRAP;
            endcase
        end
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.addr_src   = addr_src;
    assign bus.ir_we      = ir_we;
    assign bus.pc_we      = pc_we;
    assign bus.pc_src     = pc_src;
    assign bus.regwrite   = regwrite;
    assign bus.result_src = result_src;
    assign bus.alu_src    = alu_src;
    assign bus.alu_ctrl   = alu_ctrl;
    assign bus.imm_src    = imm_src;
    assign bus.illegal    = illegal;
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the shared register-file/ALU datapath (regfile, operand mux, alu) plus a single unified memory port.
- Holds no datapath state itself; drives the enables and selects each cycle from its state register and the current instruction-register contents.
- Supports the RV32I subset: R-type ALU, I-type ALU, LW, SW, BEQ, BNE, JAL. Every other encoding traps.

Parameters:
- DATA_WIDTH, 32, datapath width; only used to size instr.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- instr  in  DATA_WIDTH  instruction-register output; stable from DECODE until the next FETCH.
- eq  in  1  ALU zero flag for the current cycle's operands.
- mem_ready  in  1  memory completes the transfer on this edge when mem_req=1.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  1 = store, 0 = read.
- addr_src  out  1  0 = PC, 1 = ALUout.
- ir_we  out  1  instruction-register load.
- pc_we  out  1  PC write.
- pc_src  out  1  0 = PC+4, 1 = old_pc+imm target.
- regwrite  out  1  register-file write.
- result_src  out  2  regfile write data: 0 = ALUout, 1 = mem data, 2 = old_pc+4.
- alu_src  out  1  0 = rd2, 1 = ImmOp.
- alu_ctrl  out  3  ALU operation, encoding in package.
- imm_src  out  3  immediate format: I, S, B, J.
- illegal  out  1  sticky trap flag.

Behaviour:
- State register is registered. All outputs are combinational from state, instr and mem_ready.
- While rst_n=0: every strobe is 0 (mem_req, ir_we, pc_we, regwrite), illegal=0, and state←FETCH on the edge.
- Reset mid-operation abandons any pending transfer; mem_req is 0 in the reset cycle.
- FETCH: mem_req=1, mem_we=0, addr_src=0. On mem_ready: ir_we=1, pc_we=1, pc_src=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE: no strobes. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → TRAP
- EXEC_R / EXEC_I: alu_src=0/1 respectively, alu_ctrl from alu_decoder, then go to WB_ALU. WB_ALU: regwrite=1, result_src=0, ALU inputs held, then go to FETCH.
- alu_ctrl mapping by funct3:
  - 000 → ADD, or SUB when R-type and funct7[5]=1.
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL.
  - funct7 must be 0000000 except SUB. Any other funct3/funct7 combination, including SRA/SRAI and I-type funct3 011, goes DECODE→TRAP.
- MEM_ADDR: alu_src=1, alu_ctrl=ADD, imm_src=I for a load or S for a store. Then go to MEM_RD (load) or MEM_WR (store).
  - LW/SW with funct3≠010 go DECODE→TRAP.
- MEM_RD: mem_req=1, mem_we=0, addr_src=1. On mem_ready go to WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, addr_src=1. On mem_ready go to FETCH.
- WB_MEM: regwrite=1, result_src=1, then go to FETCH.
- BRANCH: alu_src=0, alu_ctrl=SUB, imm_src=B, pc_src=1. pc_we=eq for BEQ (funct3 000), pc_we=~eq for BNE (001). Other funct3 go DECODE→TRAP. Then go to FETCH.
- JAL: imm_src=J, pc_src=1, pc_we=1, regwrite=1, result_src=2, then go to FETCH. rd=x0 suppression is the regfile's job.
- TRAP: illegal=1, all strobes 0. Stays in TRAP until reset.
- mem_ready is ignored whenever mem_req=0.
- mem_req, mem_we and addr_src stay constant while waiting on mem_ready.
- Latency with zero wait states (mem_ready high in the request cycle):
  - R/I: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ/BNE and JAL: 3 cycles
  - Each wait state adds 1 cycle.

Decomposition:
- Package riscv_pkg holds:
  - state enum: FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, JAL, TRAP
  - opcode constants
  - alu_ctrl encoding: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111
  - imm_src encoding: I 000, S 001, B 010, J 011
  - result_src encoding
- One sub-module, alu_decoder: combinational opcode/funct3/funct7 → alu_ctrl plus a legal flag. Reused by DECODE for trap detection.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready tied 1 → FETCH, DECODE, EXEC_R, WB_ALU. regwrite=1 only in cycle 4, alu_ctrl=ADD, alu_src=0. Back in FETCH in cycle 5.
- lw x5,8(x1) (0x0080A283), 2 wait states on the data read → mem_req held 3 cycles in MEM_RD with addr_src=1, mem_we=0. Then WB_MEM with regwrite=1, result_src=1. 7 cycles total.
- beq with eq=1, then eq=0 → BRANCH: pc_we=1, pc_src=1 when taken; pc_we=0 when not taken. bne with eq=0 → pc_we=1.
- sw x2,4(x1) (0x0020A223) → MEM_WR with mem_we=1, addr_src=1; regwrite never asserted; back to FETCH after 4 cycles.
- Illegal cases, 0xFFFFFFFF and sra (0x4020D1B3) → DECODE→TRAP, illegal=1, no further mem_req. rst_n=0 for one cycle clears illegal and returns to FETCH.
- rst_n pulled low during a stalled MEM_RD → mem_req=0 that cycle, state=FETCH after the edge, no regwrite is ever issued for the abandoned load.
